// File: rtl/if_id_inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the IF->ID instruction queue.
//   NOP_INST          : instruction presented to ID while the queue is empty
//   RESET_PC_DEFAULT  : PC presented to ID while the queue is empty
//   if_entry_t        : {inst, pc} pair as held in one queue slot (32/32 build)
// -----------------------------------------------------------------------------
package if_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_entry_t;

endpackage

// File: rtl/if_id_inst_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_inst_queue_if
// Handshake bundle between instruction fetch, the instruction queue and ID.
//   flush                         : discard all queued entries
//   in_valid / in_inst / in_pc    : fetch side, data offered to the queue
//   in_ready                      : queue can accept (not full)
//   out_valid / out_inst / out_pc : ID side, head entry (NOP/RESET_PC if empty)
//   out_ready                     : ID consumes the head
//   count                         : current occupancy
// Modports: master = fetch/ID environment, slave = the queue itself.
// -----------------------------------------------------------------------------
interface if_id_inst_queue_if #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) ();

    logic                       flush;
    logic                       in_valid;
    logic [INST_W-1:0]          in_inst;
    logic [PC_W-1:0]            in_pc;
    logic                       in_ready;
    logic                       out_valid;
    logic [INST_W-1:0]          out_inst;
    logic [PC_W-1:0]            out_pc;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, count
    );

endinterface

// File: rtl/if_id_inst_queue_store.sv
// -----------------------------------------------------------------------------
// ifq_store
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset; validity is tracked by the
// pointers/count in the parent.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write slot
//   wdata_i  : write data
//   raddr_i  : read slot
//   rdata_o  : combinational read data
// -----------------------------------------------------------------------------
module ifq_store #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_inst_queue.sv
// -----------------------------------------------------------------------------
// if_id_inst_queue
// DEPTH-entry FIFO of {instruction, PC} pairs between the instruction fetch
// port and the ID stage. Absorbs stalls, flushes and back-pressure without
// re-fetching. While empty, ID sees NOP_INST at RESET_PC.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : if_id_inst_queue_if.slave (fetch side, ID side, flush, count)
//
// Configuration macro:
//   IFQ_BYPASS_EN : when defined, an empty queue forwards in_inst/in_pc to
//                   out_* in the same cycle; if ID takes it, it is never
//                   written. Undefined: minimum latency of one cycle.
// -----------------------------------------------------------------------------
module if_id_inst_queue
    import if_pkg::*;
#(
    parameter int               INST_W   = 32,
    parameter int               PC_W     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    if_id_inst_queue_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q,  count_d;
    logic                   full, empty;
    logic                   bypass, push, pop;
    logic [INST_W+PC_W-1:0] head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = empty && bus.in_valid && !bus.flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed beat taken by ID in the same cycle never touches storage.
    assign push = bus.in_valid && !full && !bus.flush && !(bypass && bus.out_ready);
    // Pop only advances over stored entries; a bypassed beat has none.
    assign pop  = !empty && bus.out_ready && !bus.flush;

    ifq_store #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W + PC_W)
    ) u_store (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.in_inst, bus.in_pc}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty || bypass;
    assign bus.count     = count_q;

    always_comb begin
        bus.out_inst = INST_W'(NOP_INST);
        bus.out_pc   = RESET_PC;
        if (!empty) begin
            bus.out_inst = head[INST_W+PC_W-1:PC_W];
            bus.out_pc   = head[PC_W-1:0];
        end else if (bypass) begin
            bus.out_inst = bus.in_inst;
            bus.out_pc   = bus.in_pc;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream offering a beat into a full queue loses it.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst) !(bus.in_valid && full && !bus.flush)
    ) else $warning("in_valid asserted while queue full; beat ignored");

endmodule

// File: doc/if_id_inst_queue.md
# if_id_inst_queue

Parametrised instruction queue between the SRAM-like instruction fetch port and the ID stage. It generalises the single-entry ID instruction/PC hold register into a DEPTH-entry FIFO of {instruction, PC} pairs with a valid/ready handshake on both sides. Stalls, flushes and back-pressure are therefore absorbed without re-fetching. When the queue is empty, ID is presented with a NOP at RESET_PC.

## Interface
Parameters:
- `INST_W`, default 32: instruction width.
- `PC_W`, default 32: PC width.
- `DEPTH`, default 4: entry count; power of two, ≥2.
- `RESET_PC`, default 32'hbfc00000: PC presented while empty.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `flush`  in  1: discard all entries (branch redirect / exception).
- `in_valid`  in  1: fetch returned data this cycle.
- `in_inst`  in  INST_W: `inst_sram_rdata`.
- `in_pc`  in  PC_W: PC of `in_inst`.
- `in_ready`  out  1: queue can accept; equals !full.
- `out_valid`  out  1: head entry valid for ID.
- `out_inst`  out  INST_W: head instruction; 0 (NOP) when !out_valid.
- `out_pc`  out  PC_W: head PC; RESET_PC when !out_valid.
- `out_ready`  in  1: ID consumes the head (ID not stalled).
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: circular buffer, `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` tracked separately. full = (count==DEPTH); empty = (count==0).
- Push fires on in_valid && in_ready && !flush: write at `wr_ptr`, increment `wr_ptr`.
- Pop fires on out_valid && out_ready && !flush: increment `rd_ptr`.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither fire.
- Full queue: in_ready=0, even when out_ready=1 (no pop-through); upstream must hold in_valid/data.
- Stall (out_ready=0): head entry and outputs held stable every cycle. This replaces the old stall-hold register.
- flush: pointers and count clear at the next edge; push and pop in the same cycle are ignored. flush has priority over every other event.
- in_valid while full is ignored (protocol violation; flagged by assertion in simulation).
- Outputs are driven combinationally from the head entry, or from NOP/RESET_PC when empty.

## Timing
- Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, out_valid=0, out_inst=0, out_pc=RESET_PC, in_ready=1. Storage contents are not reset.
- Deassertion of rst is synchronised externally; the first push may occur on the first edge after release.
- Latency without bypass: data pushed at edge N is visible on out_* after edge N, i.e. 1 cycle.
- After flush at edge N: out_valid=0 and count=0 following edge N; in_ready=1.
- Reset mid-operation: all in-flight entries are lost; outputs return to reset values immediately, without waiting for a clock.

## Configuration
- `IFQ_BYPASS_EN` defined: when empty && in_valid && !flush, out_valid=1 and out_inst/out_pc = in_inst/in_pc in the same cycle (zero latency).
  - If out_ready is also 1, the entry is consumed and not written (count stays 0).
  - If out_ready is 0, the entry is written normally.
- `IFQ_BYPASS_EN` undefined: no combinational in→out path. The minimum latency is 1 cycle.

## Structure
- Shared package `if_pkg`: `NOP_INST` (32'h0), `RESET_PC` default value, typedef `if_entry_t` {inst, pc}.
- One sub-module, `ifq_store`: DEPTH×(INST_W+PC_W) register array with one write port and one asynchronous read port. Control (pointers, count, bypass mux) stays in the top level.

## Test plan
- Reset then idle: out_valid=0, out_inst=0, out_pc=32'hbfc00000, count=0, in_ready=1.
- Push PCs bfc00000..bfc0000c (4 entries) with out_ready=0: count=4, in_ready=0, head stays bfc00000. Then set out_ready=1: pops in order over 4 cycles.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing PCs: count stays 2, FIFO order preserved across pointer wrap.
- flush with count=3 and in_valid=1 on the same edge: next cycle count=0, out_valid=0, and the pushed instruction is dropped.
- Assert rst mid-stream at count=2 between clock edges: outputs go to NOP/RESET_PC immediately.
- With IFQ_BYPASS_EN, empty queue, in_valid=1, out_ready=1, in_inst=32'h24020001: out_inst=32'h24020001 in the same cycle, count remains 0. Without the macro, the same stimulus appears one cycle later.
